// File: rtl/apb_alu_pkg.sv
// Shared constants and types for the APB ALU completer: register offsets,
// op encoding, engine states, flag bit positions and small helpers.
package apb_alu_pkg;

  // Byte offsets of the register map
  localparam logic [7:0] AddrOpa    = 8'h00;
  localparam logic [7:0] AddrOpb    = 8'h04;
  localparam logic [7:0] AddrCtrl   = 8'h08;
  localparam logic [7:0] AddrResult = 8'h0C;
  localparam logic [7:0] AddrFlags  = 8'h10;
  localparam logic [7:0] AddrStatus = 8'h14;

  localparam int unsigned CtrlStartBit  = 8;
  localparam int unsigned CtrlIeBit     = 9;
  localparam int unsigned StatusDoneBit = 1;

  // FLAGS bit indices ({v,c,n,z})
  localparam int unsigned FlagZ = 0;
  localparam int unsigned FlagN = 1;
  localparam int unsigned FlagC = 2;
  localparam int unsigned FlagV = 3;

  typedef enum logic [3:0] {
    OpAdd = 4'd0,
    OpSub = 4'd1,
    OpAnd = 4'd2,
    OpOr  = 4'd3,
    OpXor = 4'd4,
    OpSlt = 4'd5,
    OpSll = 4'd6,
    OpSrl = 4'd7,
    OpSra = 4'd8
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StDone
  } eng_state_e;

  function automatic logic is_shift(logic [3:0] op);
    return (op == OpSll) || (op == OpSrl) || (op == OpSra);
  endfunction

  // One-bit step of the iterative shifter
  function automatic logic [31:0] shift_one(logic [3:0] op, logic [31:0] a);
    logic [31:0] r;
    if (op == OpSll)      r = {a[30:0], 1'b0};
    else if (op == OpSrl) r = {1'b0, a[31:1]};
    else                  r = {a[31], a[31:1]};
    return r;
  endfunction

  // Zero/negative flags; carry and overflow left clear
  function automatic logic [3:0] zn_flags(logic [31:0] r);
    logic [3:0] f;
    f        = '0;
    f[FlagN] = r[31];
    f[FlagZ] = (r == 32'd0);
    return f;
  endfunction

endpackage

// File: rtl/apb_alu_completer_if.sv
// APB completer bus plus interrupt line for the ALU block.
interface apb_alu_completer_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        irq;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr, irq
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr, irq
  );
endinterface

// File: rtl/alu_exec.sv
// Combinational datapath for add/sub/logic/slt and flag generation.
// Shift ops and opcodes 9-15 yield zero here; shifts are iterated by the top.
module alu_exec
  import apb_alu_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [3:0]  op_i,
  output logic [31:0] result_o,
  output logic [3:0]  flags_o
);

  logic        sub;
  logic        arith;
  logic        ovf;
  logic [31:0] b_eff;
  logic [32:0] sum;

  // Shared adder (a + ~b + 1 for sub/slt) feeding result mux and flags
  always_comb begin
    sub      = (op_i != OpAdd);
    b_eff    = sub ? ~b_i : b_i;
    sum      = {1'b0, a_i} + {1'b0, b_eff} + {32'd0, sub};
    ovf      = (a_i[31] == b_eff[31]) && (sum[31] != a_i[31]);
    arith    = 1'b0;
    result_o = '0;
    case (op_i)
      OpAdd, OpSub: begin
        result_o = sum[31:0];
        arith    = 1'b1;
      end
      OpAnd: result_o = a_i & b_i;
      OpOr:  result_o = a_i | b_i;
      OpXor: result_o = a_i ^ b_i;
      OpSlt: begin
        result_o = {31'd0, sum[31] ^ ovf};
        arith    = 1'b1;
      end
      default: result_o = '0;
    endcase
    flags_o        = zn_flags(result_o);
    flags_o[FlagC] = arith & sum[32];
    flags_o[FlagV] = arith & ovf;
  end

endmodule

// File: rtl/apb_alu_completer.sv
// APB register front-end and execution engine for a small ALU.
// Optional macro APB_ALU_SLVERR_EN enables pslverr for unmapped addresses,
// writes to read-only registers and starts with an undefined opcode.
module apb_alu_completer
  import apb_alu_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  apb_alu_completer_if.slave  bus
);

  logic [31:0] opa_q, opb_q, result_q, result_d, work_q, work_d, bop_q, bop_d;
  logic [3:0]  op_q, sop_q, sop_d, flags_q, flags_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        ie_q, done_q, done_d;
  eng_state_e  state_q, state_d;

  logic [7:0]  addr;
  logic        access, busy, stall, ready, complete, wr, mapped, slverr;
  logic        ctrl_we, start_go, status_w1c;
  logic [31:0] rdata, alu_result, shift_res;
  logic [3:0]  alu_flags;

  alu_exec u_alu_exec (
    .a_i      (work_q),
    .b_i      (bop_q),
    .op_i     (sop_q),
    .result_o (alu_result),
    .flags_o  (alu_flags)
  );

  // Bus decode: wait states, write strobes, error and read mux
  always_comb begin
    addr     = bus.paddr & 8'hFC;
    access   = bus.psel & bus.penable;
    busy     = (state_q != StIdle);
    stall    = bus.pwrite ? (addr == AddrOpa || addr == AddrOpb || addr == AddrCtrl)
                          : (addr == AddrResult || addr == AddrFlags);
    ready    = !(busy && access && stall);
    complete = access && ready;
    wr       = complete && bus.pwrite;
    mapped   = (addr <= AddrStatus);
`ifdef APB_ALU_SLVERR_EN
    slverr   = complete && (!mapped ||
               (bus.pwrite && (addr == AddrResult || addr == AddrFlags)) ||
               (bus.pwrite && addr == AddrCtrl && bus.pwdata[CtrlStartBit] &&
                bus.pwdata[3:0] > 4'd8));
`else
    slverr   = 1'b0;
`endif
    // A rejected start leaves CTRL untouched
    ctrl_we    = wr && (addr == AddrCtrl) && !slverr;
    start_go   = ctrl_we && bus.pwdata[CtrlStartBit];
    status_w1c = wr && (addr == AddrStatus) && bus.pwdata[StatusDoneBit];
    rdata      = '0;
    if (access && !bus.pwrite) begin
      case (addr)
        AddrOpa:    rdata = opa_q;
        AddrOpb:    rdata = opb_q;
        AddrCtrl:   rdata = {22'd0, ie_q, 1'b0, 4'd0, op_q};
        AddrResult: rdata = result_q;
        AddrFlags:  rdata = {28'd0, flags_q};
        AddrStatus: rdata = {30'd0, done_q, busy};
        default:    rdata = '0;
      endcase
    end
  end

  assign bus.prdata  = rdata;
  assign bus.pready  = ready;
  assign bus.pslverr = slverr;
  assign bus.irq     = done_q & ie_q;

  // Software-visible operand and control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      opa_q <= '0;
      opb_q <= '0;
      op_q  <= '0;
      ie_q  <= 1'b0;
    end else begin
      if (wr && addr == AddrOpa) opa_q <= bus.pwdata;
      if (wr && addr == AddrOpb) opb_q <= bus.pwdata;
      if (ctrl_we) begin
        op_q <= bus.pwdata[3:0];
        ie_q <= bus.pwdata[CtrlIeBit];
      end
    end
  end

  // Engine next state: snapshot on start, iterate shifts, latch result, post done
  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    bop_d     = bop_q;
    sop_d     = sop_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    flags_d   = flags_q;
    done_d    = done_q;
    shift_res = (cnt_q == 5'd1) ? shift_one(sop_q, work_q) : work_q;
    if (status_w1c) done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_go) begin
          state_d = StExec;
          work_d  = opa_q;
          bop_d   = opb_q;
          sop_d   = bus.pwdata[3:0];
          cnt_d   = opb_q[4:0];
          done_d  = 1'b0;
        end
      end
      StExec: begin
        if (is_shift(sop_q) && cnt_q > 5'd1) begin
          work_d = shift_one(sop_q, work_q);
          cnt_d  = cnt_q - 5'd1;
        end else begin
          state_d = StDone;
          // Remaining count is 1 (last step) or 0 (zero shift amount)
          if (is_shift(sop_q)) begin
            result_d = shift_res;
            flags_d  = zn_flags(shift_res);
          end else begin
            result_d = alu_result;
            flags_d  = alu_flags;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // Engine state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      work_q   <= '0;
      bop_q    <= '0;
      sop_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      bop_q    <= bop_d;
      sop_q    <= sop_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_apb_alu_completer.sv
// Directed testbench for apb_alu_completer with hand-computed expectations.
module tb_apb_alu_completer;

  localparam int MaxWaits = 200;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  apb_alu_completer_if bus ();

  apb_alu_completer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ctrl;
    logic [31:0] res;
    logic [31:0] flags;
    int          waits;
  } vec_t;

  vec_t vecs[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Starts and ends just after a rising edge; leaves the bus idle
  task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int waits);
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = wr;
    bus.paddr   = addr;
    bus.pwdata  = wdata;
    @(posedge clk);
    #1;
    bus.penable = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!bus.pready && waits < MaxWaits) begin
      waits++;
      @(negedge clk);
    end
    if (waits >= MaxWaits) check_eq("pready_timeout", 32'(waits), 32'd0);
    rdata = bus.prdata;
    err   = bus.pslverr;
    @(posedge clk);
    #1;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] data, output logic err);
    logic [31:0] rd_unused;
    int          w_unused;
    apb_xfer(1'b1, addr, data, rd_unused, err, w_unused);
  endtask

  task automatic rd(input logic [7:0] addr, output logic [31:0] data, output logic err,
                    output int waits);
    apb_xfer(1'b0, addr, 32'd0, data, err, waits);
  endtask

  task automatic check_idle(input string tag, input logic exp_irq);
    @(negedge clk);
    check_eq({tag, "_irq"}, {31'd0, bus.irq}, {31'd0, exp_irq});
    check_eq({tag, "_pready"}, {31'd0, bus.pready}, 32'd1);
    check_eq({tag, "_pslverr"}, {31'd0, bus.pslverr}, 32'd0);
    check_eq({tag, "_prdata"}, bus.prdata, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    logic        exp_err;
    int          w;

`ifdef APB_ALU_SLVERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif

    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = '0;  bus.pwdata = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    check_idle("rst", 1'b0);
    rd(8'h00, d, e, w); check_eq("rst_opa", d, 32'd0);
    rd(8'h08, d, e, w); check_eq("rst_ctrl", d, 32'd0);
    rd(8'h0C, d, e, w); check_eq("rst_result", d, 32'd0);
    check_eq("rst_result_waits", 32'(w), 32'd0);
    rd(8'h10, d, e, w); check_eq("rst_flags", d, 32'd0);
    rd(8'h14, d, e, w); check_eq("rst_status", d, 32'd0);

    //              a             b             ctrl        result        flags waits
    vecs.push_back('{32'd5,        32'd7,        32'h100, 32'd12,        32'h0, 1});
    vecs.push_back('{32'h7FFFFFFF, 32'd1,        32'h100, 32'h80000000,  32'hA, 1});
    vecs.push_back('{32'd9,        32'd9,        32'h101, 32'd0,         32'h5, 1});
    vecs.push_back('{32'h0000F0F0, 32'h0000FF00, 32'h102, 32'h0000F000,  32'h0, 1});
    vecs.push_back('{32'h0000F0F0, 32'h0000FF00, 32'h103, 32'h0000FFF0,  32'h0, 1});
    vecs.push_back('{32'h0000F0F0, 32'h0000FF00, 32'h104, 32'h00000FF0,  32'h0, 1});
    vecs.push_back('{32'hFFFFFFFF, 32'd1,        32'h105, 32'd1,         32'h4, 1});
    vecs.push_back('{32'd1,        32'hFFFFFFFF, 32'h105, 32'd0,         32'h1, 1});
    vecs.push_back('{32'h80000000, 32'd4,        32'h108, 32'hF8000000,  32'h2, 4});
    vecs.push_back('{32'd1,        32'd31,       32'h106, 32'h80000000,  32'h2, 31});
    vecs.push_back('{32'h80000000, 32'd31,       32'h107, 32'd1,         32'h0, 31});
    vecs.push_back('{32'd5,        32'h20,       32'h106, 32'd5,         32'h0, 1});
    vecs.push_back('{32'd5,        32'd7,        32'h101, 32'hFFFFFFFE,  32'h2, 1});
    vecs.push_back('{32'hFFFFFFFF, 32'd1,        32'h100, 32'd0,         32'h5, 1});
    vecs.push_back('{32'd3,        32'd2,        32'h107, 32'd0,         32'h1, 2});

    foreach (vecs[i]) begin
      wr(8'h00, vecs[i].a, e);
      wr(8'h04, vecs[i].b, e);
      wr(8'h08, vecs[i].ctrl, e);
      check_eq($sformatf("v%0d_ctrl_err", i), {31'd0, e}, 32'd0);
      rd(8'h0C, d, e, w);
      check_eq($sformatf("v%0d_result", i), d, vecs[i].res);
      check_eq($sformatf("v%0d_waits", i), 32'(w), 32'(vecs[i].waits));
      check_eq($sformatf("v%0d_rd_err", i), {31'd0, e}, 32'd0);
      rd(8'h10, d, e, w);
      check_eq($sformatf("v%0d_flags", i), d, vecs[i].flags);
      rd(8'h14, d, e, w);
      check_eq($sformatf("v%0d_status", i), d, 32'h2);
    end

    // Busy visible right after a start; done follows
    wr(8'h00, 32'd5, e);
    wr(8'h04, 32'd7, e);
    wr(8'h08, 32'h100, e);
    rd(8'h14, d, e, w); check_eq("busy_status", d, 32'h1);
    rd(8'h14, d, e, w); check_eq("done_status", d, 32'h2);
    rd(8'h08, d, e, w); check_eq("ctrl_start_reads0", d, 32'h0);

    // Undefined opcode start
    wr(8'h08, 32'h10F, e);
    check_eq("badop_err", {31'd0, e}, {31'd0, exp_err});
    rd(8'h0C, d, e, w);
`ifdef APB_ALU_SLVERR_EN
    check_eq("badop_result", d, 32'd12);
    rd(8'h10, d, e, w); check_eq("badop_flags", d, 32'h0);
    rd(8'h08, d, e, w); check_eq("badop_ctrl", d, 32'h0);
`else
    check_eq("badop_result", d, 32'd0);
    rd(8'h10, d, e, w); check_eq("badop_flags", d, 32'h1);
    rd(8'h08, d, e, w); check_eq("badop_ctrl", d, 32'hF);
`endif

    // Interrupt: sub 9-9 with ie set
    wr(8'h00, 32'd9, e);
    wr(8'h04, 32'd9, e);
    wr(8'h08, 32'h301, e);
    rd(8'h0C, d, e, w); check_eq("irq_result", d, 32'd0);
    check_idle("irq_on", 1'b1);
    rd(8'h08, d, e, w); check_eq("irq_ctrl", d, 32'h201);
    wr(8'h14, 32'h1, e);
    rd(8'h14, d, e, w); check_eq("w1c_bit0_noeffect", d, 32'h2);
    wr(8'h14, 32'h2, e);
    check_idle("irq_off", 1'b0);
    rd(8'h14, d, e, w); check_eq("w1c_status", d, 32'h0);

    // Unmapped and read-only accesses
    rd(8'h20, d, e, w);
    check_eq("unmapped_rdata", d, 32'd0);
    check_eq("unmapped_err", {31'd0, e}, {31'd0, exp_err});
    rd(8'hFC, d, e, w); check_eq("unmapped_fc_rdata", d, 32'd0);
    wr(8'h0C, 32'hDEADBEEF, e);
    check_eq("ro_result_err", {31'd0, e}, {31'd0, exp_err});
    wr(8'h10, 32'hF, e);
    wr(8'h20, 32'h12345678, e);
    rd(8'h0C, d, e, w); check_eq("ro_result_kept", d, 32'd0);
    rd(8'h10, d, e, w); check_eq("ro_flags_kept", d, 32'h5);
    wr(8'h01, 32'h00001234, e);
    rd(8'h03, d, e, w); check_eq("addr_lsb_ignored", d, 32'h00001234);

    // Reset in the middle of a long shift
    wr(8'h00, 32'd1, e);
    wr(8'h04, 32'd31, e);
    wr(8'h08, 32'h306, e);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_idle("midrst", 1'b0);
    rd(8'h0C, d, e, w);
    check_eq("midrst_result", d, 32'd0);
    check_eq("midrst_waits", 32'(w), 32'd0);
    rd(8'h14, d, e, w); check_eq("midrst_status", d, 32'd0);
    rd(8'h00, d, e, w); check_eq("midrst_opa", d, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    rd(8'h14, d, e, w); check_eq("midrst_no_done", d, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_alu_completer.md
APB_ALU_COMPLETER -- requirements
Module: apb_alu_completer

Interface
REQ-001 SHALL have clk input 1: single clock; all logic on rising edge.
REQ-002 SHALL have reset input 1: synchronous, active-high reset.
REQ-003 SHALL have psel input 1 (APB select), penable input 1 (access phase), pwrite input 1 (1=write).
REQ-004 SHALL have paddr input 8 (byte address, bits [1:0] ignored) and pwdata input 32.
REQ-005 SHALL have prdata output 32, pready output 1 and pslverr output 1.
REQ-006 SHALL have irq output 1: level interrupt, STATUS.done AND CTRL.ie.
REQ-007 Register map SHALL be: 0x00 OPA rw; 0x04 OPB rw; 0x08 CTRL rw (op[3:0], start bit8 self-clearing and reads 0, ie bit9); 0x0C RESULT ro; 0x10 FLAGS ro ({v,c,n,z} in [3:0]); 0x14 STATUS (busy bit0 ro, done bit1 write-1-to-clear).

Function
REQ-008 Transfer SHALL complete in the access-phase cycle where psel=penable=pready=1; writes update registers on that edge only.
REQ-009 pready SHALL be 1 except when busy=1 during the access phase of: a read of RESULT or FLAGS, or a write to OPA, OPB or CTRL; it then stays 0 until the cycle after busy falls.
REQ-010 Op encoding SHALL be: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt (signed, result 0/1), 6 sll, 7 srl, 8 sra (shift amount OPB[4:0]).
REQ-011 Engine FSM SHALL have states IDLE, EXEC, DONE; a completed CTRL write with start=1 moves IDLE->EXEC on that edge, snapshots OPA/OPB/op, sets busy, clears done.
REQ-012 Ops 0-5 SHALL stay in EXEC for exactly 1 cycle; shifts SHALL shift 1 bit per cycle using a 5-bit down-counter, EXEC lasting max(OPB[4:0],1) cycles.
REQ-013 EXEC->DONE SHALL latch RESULT and FLAGS; DONE->IDLE next cycle, clearing busy and setting done.
REQ-014 Flags SHALL be: z = RESULT==0; n = RESULT[31]; c = adder carry-out of a+(~b or b)+sub, forced 0 unless op is 0, 1 or 5; v = signed add/sub overflow, forced 0 unless op is 0, 1 or 5.
REQ-015 Add/sub/slt SHALL use 32-bit modular arithmetic; sub computed as a+~b+1.
REQ-016 Opcodes 9-15 with start=1 SHALL run 1 EXEC cycle producing RESULT=0, FLAGS=4'b0001.
REQ-017 Unmapped-address reads SHALL return prdata=0; unmapped and read-only writes SHALL have no effect.
REQ-018 Writes to STATUS bit1=1 and a start in the same cycle SHALL leave done=0.
REQ-019 prdata SHALL be 0 when the transfer is not an access-phase read.

Reset
REQ-020 On reset, all registers, RESULT, FLAGS, STATUS, counter SHALL clear to 0, FSM to IDLE, pready=1, pslverr=0, irq=0, prdata=0, including mid-operation (shift abandoned, no done).

Configuration
REQ-021 Macro APB_ALU_SLVERR_EN defined: pslverr=1 on the completing cycle for unmapped addresses, writes to RESULT/FLAGS, and CTRL starts with op 9-15 (start suppressed, register unchanged).
REQ-022 Macro APB_ALU_SLVERR_EN undefined: pslverr tied 0; behaviour per REQ-016/REQ-017.

Structure
REQ-023 Package apb_alu_pkg SHALL hold register offset constants, op encoding enum (4-bit), FSM state enum, FLAGS bit indices.
REQ-024 Single sub-module alu_exec SHALL hold the combinational add/sub/logic/slt datapath and flag generation; shift iteration and FSM SHALL stay in apb_alu_completer.

Verification
REQ-025 OPA=5, OPB=7, CTRL=0x100 -> busy for 2 cycles after the write, RESULT=12, FLAGS=0x0, STATUS=0x2.
REQ-026 OPA=0x7FFFFFFF, OPB=1, op add -> RESULT=0x80000000, FLAGS=0xA (v=1, n=1).
REQ-027 OPA=9, OPB=9, op sub -> RESULT=0, FLAGS=0x5 (c=1, z=1); CTRL ie=1 -> irq=1 until STATUS write 0x2.
REQ-028 OPA=0x80000000, OPB=4, CTRL=0x108, immediate RESULT read -> pready=0 until done, prdata=0xF8000000, pslverr=0.
REQ-029 Read paddr 0x20 -> prdata=0; pslverr=1 with APB_ALU_SLVERR_EN, 0 without.
REQ-030 Start sll with OPB=31, assert reset 10 cycles later -> next cycle busy=0, done=0, RESULT=0, pready=1.
